// File: rtl/arm_pkg.sv
// Shared ARM condition-code encodings and NZCV flag bit positions.
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Controller <-> conditional-execution unit signal bundle.
interface cond_logic_if;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       CondLatch;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondEx;

    modport master (
        output Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC, RegW, MemW,
        input  PCWrite, RegWrite, MemWrite, Flags, CondEx
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC, RegW, MemW,
        output PCWrite, RegWrite, MemWrite, Flags, CondEx
    );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition decoder over the stored NZCV flags.
module cond_check
    import arm_pkg::*;
#(
    parameter bit NV_IS_ALWAYS = 1'b0
) (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx_comb
);
    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx_comb = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx_comb = z;
            COND_NE: CondEx_comb = ~z;
            COND_CS: CondEx_comb = c;
            COND_CC: CondEx_comb = ~c;
            COND_MI: CondEx_comb = n;
            COND_PL: CondEx_comb = ~n;
            COND_VS: CondEx_comb = v;
            COND_VC: CondEx_comb = ~v;
            COND_HI: CondEx_comb = c & ~z;
            COND_LS: CondEx_comb = ~c | z;
            COND_GE: CondEx_comb = ~(n ^ v);
            COND_LT: CondEx_comb = n ^ v;
            COND_GT: CondEx_comb = ~z & ~(n ^ v);
            COND_LE: CondEx_comb = z | (n ^ v);
            COND_AL: CondEx_comb = 1'b1;
            COND_NV: CondEx_comb = NV_IS_ALWAYS;
            default: CondEx_comb = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: stored NZCV flags, latched condition result and
// write-enable gating for a multicycle ARM controller.
module cond_logic
    import arm_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS  = 4'b0000,
    parameter bit         NV_IS_ALWAYS = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;
    logic       cond_ex_comb;

    // Decoder sees the stored flags, so a same-cycle flag write cannot affect it.
    cond_check #(
        .NV_IS_ALWAYS (NV_IS_ALWAYS)
    ) u_cond_check (
        .Cond        (bus.Cond),
        .Flags       (flags_q),
        .CondEx_comb (cond_ex_comb)
    );

    always_comb begin
        flags_d = flags_q;
        if (cond_ex_q && bus.FlagW[1]) begin
            flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
        end
        if (cond_ex_q && bus.FlagW[0]) begin
            flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
            flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
        end
    end

    always_comb begin
        cond_ex_d = cond_ex_q;
        if (bus.CondLatch) begin
            cond_ex_d = cond_ex_comb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= RESET_FLAGS;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    assign bus.Flags    = flags_q;
    assign bus.CondEx   = cond_ex_q;
    assign bus.RegWrite = bus.RegW & cond_ex_q;
    assign bus.MemWrite = bus.MemW & cond_ex_q;
    assign bus.PCWrite  = (bus.PCS & cond_ex_q) | bus.NextPC;
endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: two instances (NV never / NV always with
// non-zero reset flags) share one stimulus stream.
module tb_cond_logic;
    import arm_pkg::*;

    logic clk;
    logic reset;

    cond_logic_if ifc0 ();
    cond_logic_if ifc1 ();

    cond_logic #(
        .RESET_FLAGS  (4'b0000),
        .NV_IS_ALWAYS (1'b0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc0)
    );

    cond_logic #(
        .RESET_FLAGS  (4'b1010),
        .NV_IS_ALWAYS (1'b1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc1)
    );

    assign ifc1.Cond      = ifc0.Cond;
    assign ifc1.ALUFlags  = ifc0.ALUFlags;
    assign ifc1.FlagW     = ifc0.FlagW;
    assign ifc1.CondLatch = ifc0.CondLatch;
    assign ifc1.PCS       = ifc0.PCS;
    assign ifc1.NextPC    = ifc0.NextPC;
    assign ifc1.RegW      = ifc0.RegW;
    assign ifc1.MemW      = ifc0.MemW;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] flags;
        logic       cx;
        logic       rw;
        logic       mw;
        logic       pw;
        logic [3:0] flags1;
        logic       cx1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f, input bit nv);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return nv;
        endcase
    endfunction

    task automatic chk(input string name, input string what, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %b expected %b", name, what, act, exp);
        end
    endtask

    // Each cycle: drive inputs, queue the outputs expected before the next edge.
    task automatic step(input logic rst, input logic [3:0] cond, input logic latch,
                        input logic [1:0] fw, input logic [3:0] alu,
                        input logic regw, input logic memw, input logic pcs, input logic npc,
                        input bit do_chk, input string nm,
                        input logic [3:0] ef, input logic ec, input logic er, input logic em,
                        input logic ep, input logic [3:0] ef1, input logic ec1);
        exp_t e;
        reset          = rst;
        ifc0.Cond      = cond;
        ifc0.CondLatch = latch;
        ifc0.FlagW     = fw;
        ifc0.ALUFlags  = alu;
        ifc0.RegW      = regw;
        ifc0.MemW      = memw;
        ifc0.PCS       = pcs;
        ifc0.NextPC    = npc;
        if (do_chk) begin
            e.name = nm; e.flags = ef; e.cx = ec; e.rw = er; e.mw = em; e.pw = ep;
            e.flags1 = ef1; e.cx1 = ec1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "Flags",    ifc0.Flags,           e.flags);
                chk(e.name, "CondEx",   {3'b0, ifc0.CondEx},   {3'b0, e.cx});
                chk(e.name, "RegWrite", {3'b0, ifc0.RegWrite}, {3'b0, e.rw});
                chk(e.name, "MemWrite", {3'b0, ifc0.MemWrite}, {3'b0, e.mw});
                chk(e.name, "PCWrite",  {3'b0, ifc0.PCWrite},  {3'b0, e.pw});
                chk(e.name, "Flags_nv1",  ifc1.Flags,          e.flags1);
                chk(e.name, "CondEx_nv1", {3'b0, ifc1.CondEx}, {3'b0, e.cx1});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pats [5];
        logic [3:0] f0, f1, p;
        logic       c0, c1;
        pats[0] = 4'b0000; pats[1] = 4'b0110; pats[2] = 4'b1001;
        pats[3] = 4'b0011; pats[4] = 4'b1101;

        //   rst cond     lt fw     alu      rw mw pc np  chk name            flags   cx rw mw pw flags1  cx1
        step(1, COND_AL, 1, 2'b11, 4'b1111, 1, 1, 1, 0,  0, "pre",          4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        step(1, COND_AL, 1, 2'b11, 4'b1111, 1, 1, 1, 0,  1, "rst_override", 4'b0000, 0, 0, 0, 0, 4'b1010, 0);
        step(1, COND_AL, 1, 2'b11, 4'b1111, 1, 1, 1, 1,  1, "rst_npc",      4'b0000, 0, 0, 0, 1, 4'b1010, 0);
        step(0, COND_AL, 1, 2'b00, 4'b0000, 1, 0, 0, 0,  1, "post_rst",     4'b0000, 0, 0, 0, 0, 4'b1010, 0);
        step(0, COND_AL, 0, 2'b00, 4'b0000, 1, 0, 0, 0,  1, "al_regw",      4'b0000, 1, 1, 0, 0, 4'b1010, 1);
        step(0, COND_AL, 0, 2'b11, 4'b0100, 0, 0, 0, 0,  1, "flag_wr",      4'b0000, 1, 0, 0, 0, 4'b1010, 1);
        step(0, COND_EQ, 1, 2'b00, 4'b0000, 0, 1, 0, 0,  1, "eq_latch",     4'b0100, 1, 0, 1, 0, 4'b0100, 1);
        step(0, COND_EQ, 0, 2'b00, 4'b0000, 0, 1, 0, 0,  1, "eq_memw",      4'b0100, 1, 0, 1, 0, 4'b0100, 1);
        step(0, COND_NE, 1, 2'b00, 4'b0000, 0, 1, 0, 0,  1, "ne_latch",     4'b0100, 1, 0, 1, 0, 4'b0100, 1);
        step(0, COND_NE, 0, 2'b00, 4'b0000, 1, 1, 0, 0,  1, "ne_gated",     4'b0100, 0, 0, 0, 0, 4'b0100, 0);
        step(0, COND_NE, 0, 2'b11, 4'b1010, 0, 0, 1, 0,  1, "pcs_gated",    4'b0100, 0, 0, 0, 0, 4'b0100, 0);
        step(0, COND_NE, 0, 2'b00, 4'b0000, 0, 0, 1, 1,  1, "npc_ungated",  4'b0100, 0, 0, 0, 1, 4'b0100, 0);
        step(0, COND_AL, 1, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "al_relatch",   4'b0100, 0, 0, 0, 0, 4'b0100, 0);
        step(0, COND_AL, 0, 2'b11, 4'b1111, 0, 0, 0, 0,  1, "set_all",      4'b0100, 1, 0, 0, 0, 4'b0100, 1);
        step(0, COND_AL, 0, 2'b10, 4'b0000, 0, 0, 0, 0,  1, "fw_nz_only",   4'b1111, 1, 0, 0, 0, 4'b1111, 1);
        step(0, COND_AL, 0, 2'b01, 4'b1100, 0, 0, 0, 0,  1, "fw_cv_only",   4'b0011, 1, 0, 0, 0, 4'b0011, 1);
        step(0, COND_AL, 0, 2'b11, 4'b1000, 0, 0, 1, 0,  1, "pcs_taken",    4'b0000, 1, 0, 0, 1, 4'b0000, 1);
        step(0, COND_GE, 1, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "n1v0_set",     4'b1000, 1, 0, 0, 0, 4'b1000, 1);
        step(0, COND_LT, 1, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "ge_result",    4'b1000, 0, 0, 0, 0, 4'b1000, 0);
        step(0, COND_GT, 1, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "lt_result",    4'b1000, 1, 0, 0, 0, 4'b1000, 1);
        step(0, COND_LE, 1, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "gt_result",    4'b1000, 0, 0, 0, 0, 4'b1000, 0);
        step(0, COND_NV, 1, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "le_result",    4'b1000, 1, 0, 0, 0, 4'b1000, 1);
        step(0, COND_AL, 1, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "nv_result",    4'b1000, 0, 0, 0, 0, 4'b1000, 1);
        step(0, COND_MI, 1, 2'b11, 4'b0100, 0, 0, 0, 0,  1, "al_again",     4'b1000, 1, 0, 0, 0, 4'b1000, 1);
        step(0, COND_PL, 1, 2'b11, 4'b1000, 0, 0, 0, 0,  1, "mi_old_flags", 4'b0100, 1, 0, 0, 0, 4'b0100, 1);
        step(0, COND_EQ, 1, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "pl_old_flags", 4'b1000, 1, 0, 0, 0, 4'b1000, 1);
        step(0, COND_AL, 1, 2'b11, 4'b0001, 0, 0, 0, 0,  1, "eq_clear",     4'b1000, 0, 0, 0, 0, 4'b1000, 0);
        step(0, COND_AL, 0, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "gated_by_old", 4'b1000, 1, 0, 0, 0, 4'b1000, 1);
        step(1, COND_AL, 0, 2'b11, 4'b0110, 0, 0, 0, 0,  1, "pre_rst",      4'b1000, 1, 0, 0, 0, 4'b1000, 1);
        step(0, COND_AL, 0, 2'b00, 4'b0000, 0, 0, 0, 0,  1, "rst_abandon",  4'b0000, 0, 0, 0, 0, 4'b1010, 0);

        // Condition table sweep over several flag patterns.
        f0 = 4'b0000; f1 = 4'b1010; c0 = 1'b0; c1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            p = pats[k];
            step(0, COND_AL, 1, 2'b00, 4'b0000, 1, 0, 1, 0, 1, "loop_al", f0, c0, c0, 0, c0, f1, c1);
            step(0, COND_AL, 0, 2'b11, p, 1, 0, 1, 0, 1, "loop_load", f0, 1, 1, 0, 1, f1, 1);
            f0 = p; f1 = p; c0 = 1'b1; c1 = 1'b1;
            for (int c = 0; c < 16; c++) begin
                step(0, 4'(c), 1, 2'b00, 4'b0000, 1, 0, 1, 0, 1,
                     $sformatf("cond_prev_of_%0d_f%b", c, p), p, c0, c0, 0, c0, p, c1);
                c0 = cond_ref(4'(c), p, 1'b0);
                c1 = cond_ref(4'(c), p, 1'b1);
            end
        end
        step(0, COND_AL, 0, 2'b00, 4'b0000, 1, 0, 1, 0, 1, "cond_last", f0, c0, c0, 0, c0, f1, c1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
